// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 16-bit ALU: owns PC, IR, MDR, W and C/Z flags,
// and sequences instruction and operand accesses over a request/acknowledge memory bus.
module alu_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic [15:0] alu_mem,
    output logic [15:0] alu_wreg,
    output logic        alu_carry,
    output logic        alu_zero,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_carry_out,
    input  logic        alu_zero_out,
    input  logic        alu_pc_skip,
    output logic        halted,
    output logic [11:0] pc,
    output logic [15:0] w
);

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_OPREAD, S_EXEC, S_STORE, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] w_q, w_d;
    logic        c_q, c_d;
    logic        z_q, z_d;

    logic [3:0]  opc;
    logic [11:0] addr_a;

    assign opc    = ir_q[15:12];
    assign addr_a = ir_q[11:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        w_d     = w_q;
        c_d     = c_q;
        z_d     = z_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (bus_ack) begin
                    ir_d    = bus_rdata;
                    pc_d    = pc_q + 12'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opc)
                    4'hA: state_d = S_STORE;
                    4'hB: begin
                        pc_d    = addr_a;
                        state_d = S_FETCH;
                    end
                    4'hC: begin
                        c_d     = 1'b0;
                        state_d = S_FETCH;
                    end
                    4'hD: begin
                        c_d     = 1'b1;
                        state_d = S_FETCH;
                    end
                    4'hE: state_d = S_FETCH;
                    4'hF: state_d = S_HALT;
                    default: state_d = S_OPREAD;
                endcase
            end
            S_OPREAD: begin
                if (bus_ack) begin
                    mdr_d   = bus_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // 0x8/0x9 are test ops: they only steer the PC, never W or flags
                if (opc <= 4'h7) begin
                    w_d = alu_result;
                    c_d = alu_carry_out;
                    z_d = alu_zero_out;
                end else if (alu_pc_skip) begin
                    pc_d = pc_q + 12'd1;
                end
                state_d = S_FETCH;
            end
            S_STORE: begin
                if (bus_ack) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            mdr_q   <= 16'h0000;
            w_q     <= 16'h0000;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            w_q     <= w_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Requests come straight off the state register, so reset drops them asynchronously.
    assign bus_rd    = (state_q == S_FETCH) || (state_q == S_OPREAD);
    assign bus_wr    = (state_q == S_STORE);
    assign bus_addr  = (state_q == S_FETCH) ? pc_q :
                       ((state_q == S_OPREAD) || (state_q == S_STORE)) ? addr_a : 12'h000;
    assign bus_wdata = w_q;

    assign alu_mem   = mdr_q;
    assign alu_wreg  = w_q;
    assign alu_carry = c_q;
    assign alu_zero  = z_q;
    assign alu_op    = (state_q == S_EXEC) ? opc : 4'hF;

    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;
    assign w         = w_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench for alu_sequencer: a small memory responder and ALU model drive the DUT,
// expected bus transactions (with their cycle) are queued and checked by an independent monitor.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bus_addr;
    logic        bus_rd, bus_wr;
    logic [15:0] bus_wdata, bus_rdata;
    logic        bus_ack;
    logic [15:0] alu_mem, alu_wreg;
    logic        alu_carry, alu_zero;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_carry_out, alu_zero_out, alu_pc_skip;
    logic        halted;
    logic [11:0] pc;
    logic [15:0] w;

    alu_sequencer #(.RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .alu_mem(alu_mem), .alu_wreg(alu_wreg), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_op(alu_op), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .alu_zero_out(alu_zero_out), .alu_pc_skip(alu_pc_skip),
        .halted(halted), .pc(pc), .w(w)
    );

    always #5 clk = ~clk;

    // Memory responder: combinational ack after a programmable number of wait cycles.
    logic [15:0] mem [0:4095];
    int          wcnt = 0;
    int          wr_wait = 0;
    int          stall_addr = -1;
    int          need;
    logic        req;

    assign req       = bus_rd | bus_wr;
    assign need      = bus_wr ? wr_wait : ((int'(bus_addr) == stall_addr) ? 100000 : 0);
    assign bus_ack   = req && (wcnt >= need);
    assign bus_rdata = mem[bus_addr];

    always @(posedge clk) begin
        if (req && !bus_ack) wcnt <= wcnt + 1;
        else                 wcnt <= 0;
    end

    // ALU model: 0 RotL/1 RotR through C, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 MOV, 8 skip-nz, 9 skip-z.
    logic [16:0] t;
    always_comb begin
        t             = 17'h0;
        alu_result    = 16'h0;
        alu_carry_out = alu_carry;
        alu_pc_skip   = 1'b0;
        case (alu_op)
            4'h0: begin alu_result = {alu_mem[14:0], alu_carry}; alu_carry_out = alu_mem[15]; end
            4'h1: begin alu_result = {alu_carry, alu_mem[15:1]}; alu_carry_out = alu_mem[0]; end
            4'h2: begin t = {1'b0, alu_wreg} + {1'b0, alu_mem}; alu_result = t[15:0]; alu_carry_out = t[16]; end
            4'h3: begin t = {1'b0, alu_wreg} - {1'b0, alu_mem}; alu_result = t[15:0]; alu_carry_out = t[16]; end
            4'h4: alu_result = alu_wreg & alu_mem;
            4'h5: alu_result = alu_wreg | alu_mem;
            4'h6: alu_result = alu_wreg ^ alu_mem;
            4'h7: alu_result = alu_mem;
            4'h8: alu_pc_skip = (alu_mem != 16'h0);
            4'h9: alu_pc_skip = (alu_mem == 16'h0);
            default: ;
        endcase
        alu_zero_out = (alu_result == 16'h0);
    end

    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_pass = 0;
    int req_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } txn_t;
    txn_t sb[$];

    task automatic exp_rd(input logic [11:0] a, input int c);
        txn_t x;
        x.wr = 1'b0; x.addr = a; x.data = 16'h0; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic exp_wr(input logic [11:0] a, input logic [15:0] d, input int c);
        txn_t x;
        x.wr = 1'b1; x.addr = a; x.data = d; x.cyc = c;
        sb.push_back(x);
    endtask

    // Monitor: every completed bus transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && req) req_cnt <= req_cnt + 1;
        if (rst_n && req && bus_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_txn", {19'h0, bus_wr, bus_addr}, 32'hFFFF_FFFF);
            end else begin
                txn_t e;
                e = sb.pop_front();
                chk("txn_kind", {31'h0, bus_wr}, {31'h0, e.wr});
                chk("txn_addr", {20'h0, bus_addr}, {20'h0, e.addr});
                chk("txn_cycle", cyc, e.cyc);
                if (e.wr) chk("txn_wdata", {16'h0, bus_wdata}, {16'h0, e.data});
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
        mem[12'h000] = 16'h2010; mem[12'h001] = 16'h7013; mem[12'h002] = 16'h2011;
        mem[12'h003] = 16'h0011; mem[12'h004] = 16'hE000; mem[12'h005] = 16'h9012;
        mem[12'h007] = 16'h9014; mem[12'h008] = 16'hD000; mem[12'h009] = 16'hC000;
        mem[12'h00A] = 16'h7015; mem[12'h00B] = 16'hA020; mem[12'h00C] = 16'hBFFE;
        mem[12'hFFE] = 16'hBFFF; mem[12'hFFF] = 16'hE000;
        mem[12'h010] = 16'h0005; mem[12'h011] = 16'h0001; mem[12'h012] = 16'h0000;
        mem[12'h013] = 16'hFFFF; mem[12'h014] = 16'h0001; mem[12'h015] = 16'hBEEF;
        wr_wait = 3;

        exp_rd(12'h000, 1);  exp_rd(12'h010, 3);  exp_rd(12'h001, 5);  exp_rd(12'h013, 7);
        exp_rd(12'h002, 9);  exp_rd(12'h011, 11); exp_rd(12'h003, 13); exp_rd(12'h011, 15);
        exp_rd(12'h004, 17); exp_rd(12'h005, 19); exp_rd(12'h012, 21); exp_rd(12'h007, 23);
        exp_rd(12'h014, 25); exp_rd(12'h008, 27); exp_rd(12'h009, 29); exp_rd(12'h00A, 31);
        exp_rd(12'h015, 33); exp_rd(12'h00B, 35); exp_wr(12'h020, 16'hBEEF, 40);
        exp_rd(12'h00C, 41); exp_rd(12'hFFE, 43); exp_rd(12'hFFF, 45); exp_rd(12'h000, 47);

        repeat (3) @(negedge clk);
        chk("rst_rd", {31'h0, bus_rd}, 0);
        chk("rst_wr", {31'h0, bus_wr}, 0);
        chk("rst_op", {28'h0, alu_op}, 32'hF);
        chk("rst_halted", {31'h0, halted}, 0);
        chk("rst_pc", {20'h0, pc}, 0);
        chk("rst_wcz", {14'h0, w, alu_carry, alu_zero}, 0);
        rst_n = 1'b1;

        wait_cyc(4);
        chk("exec_op", {28'h0, alu_op}, 32'h2);
        chk("exec_mem", {16'h0, alu_mem}, 32'h5);
        wait_cyc(5);
        chk("add_wcz", {14'h0, w, alu_carry, alu_zero}, {14'h0, 16'h0005, 2'b00});
        chk("add_pc", {20'h0, pc}, 32'h1);
        wait_cyc(13);
        chk("wrap_wcz", {14'h0, w, alu_carry, alu_zero}, {14'h0, 16'h0000, 2'b11});
        wait_cyc(17);
        chk("rotl_wcz", {14'h0, w, alu_carry, alu_zero}, {14'h0, 16'h0003, 2'b00});
        wait_cyc(20);
        mem[12'h000] = 16'hF000;
        wait_cyc(23);
        chk("skip_wcz", {14'h0, w, alu_carry, alu_zero}, {14'h0, 16'h0003, 2'b00});
        wait_cyc(29);
        chk("setc", {31'h0, alu_carry}, 1);
        wait_cyc(31);
        chk("clrc", {31'h0, alu_carry}, 0);
        for (int k = 37; k <= 40; k++) begin
            wait_cyc(k);
            chk("stw_hold", {bus_rd, bus_wr, bus_addr, bus_wdata}, {1'b0, 1'b1, 12'h020, 16'hBEEF});
        end

        for (int k = 0; k < 200 && !halted; k++) @(negedge clk);
        chk("halt_cycle", cyc, 49);
        chk("halt_op", {28'h0, alu_op}, 32'hF);
        begin
            int r0;
            r0 = req_cnt;
            repeat (20) @(negedge clk);
            chk("halt_quiet", req_cnt - r0, 0);
            chk("halt_hold", {31'h0, halted}, 1);
        end
        chk("sb_drain1", sb.size(), 0);

        // Reset during a stalled operand read.
        rst_n = 1'b0;
        mem[12'h000] = 16'h7015;
        mem[12'h001] = 16'h2010;
        stall_addr = 12'h010;
        exp_rd(12'h000, 1); exp_rd(12'h015, 3); exp_rd(12'h001, 5);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(9);
        chk("stall_req", {bus_rd, bus_wr, bus_addr}, {1'b1, 1'b0, 12'h010});
        chk("stall_w", {16'h0, w}, 32'hBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drop", {30'h0, bus_rd, bus_wr}, 0);
        chk("async_w", {16'h0, w}, 0);
        stall_addr = -1;
        exp_rd(12'h000, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_start", {bus_rd, pc, w, alu_carry, alu_zero}, 0);
        wait_cyc(2);
        chk("sb_drain2", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle fetch/decode/execute controller driving the 16-bit ALU from the other side of its port set. Owns the PC, instruction register, working register W and the carry/zero flags. Fetches instructions and operands over a simple request/acknowledge memory bus, presents operands and `alu_op` to the ALU, and commits `result`, `carry_out`, `zero_out` and `pc_skip`. Sits between program/data memory and the ALU as the core's control path.

## Interface
- `RESET_PC`, 12'h000, PC value loaded on reset.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus_addr` out 12: memory word address.
- `bus_rd` out 1: read request, held until acknowledged.
- `bus_wr` out 1: write request, held until acknowledged.
- `bus_wdata` out 16: write data; equals W.
- `bus_rdata` in 16: read data, valid in the cycle `bus_ack`=1.
- `bus_ack` in 1: completes the pending request in the same cycle.
- `alu_mem` out 16: ALU `mem` operand (operand data register, MDR).
- `alu_wreg` out 16: ALU `wreg` operand (W).
- `alu_carry` out 1, `alu_zero` out 1: flag inputs to the ALU (C, Z).
- `alu_op` out 4: ALU operation code.
- `alu_result` in 16, `alu_carry_out` in 1, `alu_zero_out` in 1, `alu_pc_skip` in 1: ALU outputs.
- `halted` out 1: high in HALT.
- `pc` out 12, `w` out 16: debug views of PC and W.

## Operation
- Instruction word: [15:12] opcode, [11:0] address `a`.
- Opcodes 0x0–0x9: ALU op with the same code. Operand is mem[a]. Ops 0x0–0x7 write `alu_result` to W, `alu_carry_out` to C and `alu_zero_out` to Z. Ops 0x8/0x9 write nothing; if `alu_pc_skip` is set, PC increments one extra.
- 0xA STW: mem[a] <= W. 0xB JMP: PC <= a. 0xC CLRC: C <= 0. 0xD SETC: C <= 1. 0xE NOP. 0xF HALT.
- States and transitions:
  - START: no request. Always goes to FETCH.
  - FETCH: `bus_rd`=1, `bus_addr`=PC. On ack: IR <= `bus_rdata`, PC <= PC+1, go to DECODE.
  - DECODE:
    - 0x0–0x9: go to OPREAD.
    - 0xA: go to STORE.
    - 0xB: PC <= a, go to FETCH.
    - 0xC/0xD/0xE: apply, go to FETCH.
    - 0xF: go to HALT.
  - OPREAD: `bus_rd`=1, `bus_addr`=a. On ack: MDR <= `bus_rdata`, go to EXEC.
  - EXEC: `alu_op`=IR[15:12]. Commit as above, go to FETCH.
  - STORE: `bus_wr`=1, `bus_addr`=a, `bus_wdata`=W. On ack, go to FETCH.
  - HALT: terminal until reset. `halted`=1.
- `alu_op`=4'hF (Nop) in every state except EXEC.
- `bus_rd`/`bus_wr` are decoded from the state register. They are never both high.
- Address in non-bus states is don't-care, driven 0.
- Arithmetic: PC is 12-bit modulo. 12'hFFF+1 = 12'h000, including the skip increment.
- `bus_ack` with no request pending is ignored.
- Reset values: state START, PC=`RESET_PC`, IR=0, MDR=0, W=0, C=0, Z=0. All bus requests 0, `alu_op`=4'hF, `halted`=0.
- Reset asserted mid-transaction drops the request asynchronously. No partial commit.

## Timing
- Wait states: each bus state stays put while `bus_ack`=0. Request and address are stable throughout.
- Zero-wait-state latency (ack in the request cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, OPREAD, EXEC).
  - STW: 3 cycles.
  - JMP, CLRC, SETC, NOP: 2 cycles.
  - First fetch starts 1 cycle after `rst_n` deasserts (START).
- Each wait state on a bus access adds one cycle.
- ALU is combinational. Its outputs are sampled at the end of EXEC.
- Flags and W are visible on `alu_carry`/`alu_zero`/`alu_wreg` from the cycle after commit.
- Skip: an instruction at PC p with `alu_pc_skip`=1 makes the next fetch p+2; otherwise p+1.

## Test plan
- Reset, zero-wait memory, mem[0]=0x2010 (ADD 0x010), mem[0x10]=0x0005, W=0 -> fetch at cycle 1. W=0x0005, Z=0, C=0 after 4 cycles. Next fetch address 0x001.
- W=0xFFFF, execute 0x2011 with mem[0x11]=0x0001 -> W=0x0000, C=1, Z=1. Then 0x0011 (RotL of 0x0001 with C=1) -> W=0x0003, C=0.
- 0x9012 at PC 5 with mem[0x12]=0 -> next fetch 0x007. With mem[0x12]=0x0001 -> next fetch 0x006. W and flags unchanged in both cases.
- STW 0xA020 with W=0xBEEF and `bus_ack` delayed 3 cycles -> `bus_wr`, addr 0x020 and data 0xBEEF held stable for 4 cycles, one write. Instruction takes 6 cycles.
- JMP at 12'hFFE to 0xFFF, then NOP at 0xFFF -> next fetch 0x000. HALT -> `halted`=1, no further requests for 20 cycles.
- Drop `rst_n` during an OPREAD wait -> `bus_rd` falls immediately. After release: START, then fetch at `RESET_PC` with W/C/Z=0.
